// File: rtl/mem_access_sequencer.sv
// Sequences core loads/stores onto a word-wide synchronous memory, with read-modify-write for sub-word stores.
// Optional misalignment trap enabled by defining MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN.
module mem_access_sequencer #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
`ifdef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  localparam int OFF_W   = $clog2(XLEN / 8);
  localparam int SZ_FULL = OFF_W;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  // log2 of the access size in bytes; anything not legal for XLEN becomes a full-width access
  function automatic logic [1:0] accessSize(input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      3'b000, 3'b100: sz = 2'd0;
      3'b001, 3'b101: sz = 2'd1;
      3'b010, 3'b110: sz = 2'd2;
      default:        sz = 2'(SZ_FULL);
    endcase
    return sz;
  endfunction

  function automatic logic [OFF_W-1:0] alignOff(input logic [OFF_W-1:0] off, input logic [1:0] sz);
    logic [OFF_W-1:0] m;
    m = OFF_W'((1 << sz) - 1);
    return off & ~m;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              store_q, store_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              mis_q, mis_d;

  logic [1:0]        size;
  logic [OFF_W-1:0]  off;
  logic [6:0]        accW, laneSh, padSh;
  logic [XLEN-1:0]   shifted, topAl, zext, sext, loadExt, laneMask, merged;
  logic signed [XLEN-1:0] topS;
  logic [1:0]        reqSize;
  logic              reqFull;

  // Lane extraction and merge work on the captured request, against the word coming back from memory
  always_comb begin
    size     = accessSize(funct3_q);
    off      = alignOff(addr_q[OFF_W-1:0], size);
    accW     = 7'(8 << size);
    laneSh   = 7'({off, 3'b000});
    padSh    = 7'(XLEN) - accW;
    shifted  = mem_rdata >> laneSh;
    topAl    = shifted << padSh;
    topS     = topAl;
    zext     = topAl >> padSh;
    sext     = topS >>> padSh;
    loadExt  = funct3_q[2] ? zext : sext;
    laneMask = ({XLEN{1'b1}} >> padSh) << laneSh;
    merged   = (mem_rdata & ~laneMask) | ((word_q << laneSh) & laneMask);
    reqSize  = accessSize(req_funct3);
    reqFull  = (reqSize == 2'(SZ_FULL));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          store_d  = req_store;
          word_d   = req_wdata;
          rdata_d  = '0;
          mis_d    = 1'b0;
          if (req_store && reqFull) state_d = WRITE;
          else                      state_d = READ;
`ifdef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
          if (req_addr[OFF_W-1:0] != alignOff(req_addr[OFF_W-1:0], reqSize)) begin
            state_d = RESP;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = 2'(MEM_LATENCY - 1);
      end
      // Last WAIT cycle is the one where mem_rdata is valid
      WAIT: begin
        if (cnt_q == 2'd0) begin
          if (store_q) begin
            word_d  = merged;
            state_d = WRITE;
          end else begin
            rdata_d = loadExt;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      word_q   <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
    end
  end

  // Strobes decode straight from state so reset removes them without waiting for a clock
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_re     = (state_q == READ);
  assign mem_we     = (state_q == WRITE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata  = word_q;
`ifdef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
  assign misaligned = mis_q && resp_valid;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: a 32-bit instance (latency 1) and a 64-bit instance (latency 3).
// Also covers MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN when that macro is defined.
module tb_mem_access_sequencer;

  localparam int LA = 1;
  localparam int LB = 3;

  typedef struct {
    int         sel;
    int         cyc;
    logic [63:0] addr;
    logic [63:0] data;
    logic       mis;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ev_t reQ[$];
  ev_t weQ[$];
  ev_t rspQ[$];

  logic        aValid = 0, aStore = 0, aReady, aRespV, aRe, aWe, aBusy, aMis;
  logic [2:0]  aF3 = 0;
  logic [31:0] aAddr = 0, aWdata = 0, aRdata, aMAddr, aMWdata, aMRdata = 0;
  logic        bValid = 0, bStore = 0, bReady, bRespV, bRe, bWe, bBusy, bMis;
  logic [2:0]  bF3 = 0;
  logic [31:0] bAddr = 0, bMAddr;
  logic [63:0] bWdata = 0, bRdata, bMWdata, bMRdata = 0;

  logic [63:0] memA [int unsigned];
  logic [63:0] memB [int unsigned];
  logic [31:0] rdDataA;
  logic [63:0] rdDataB;

  always #5 clock = ~clock;

  // Cycle counter: value seen at a negedge is the number of the current cycle
  always @(posedge clock) cyc <= cyc + 1;

  mem_access_sequencer #(.XLEN(32), .ADDR_W(32), .MEM_LATENCY(LA)) uA (
    .clock(clock), .reset(reset), .req_valid(aValid), .req_ready(aReady), .req_store(aStore),
    .req_funct3(aF3), .req_addr(aAddr), .req_wdata(aWdata), .resp_valid(aRespV), .resp_rdata(aRdata),
    .mem_addr(aMAddr), .mem_re(aRe), .mem_we(aWe), .mem_wdata(aMWdata), .mem_rdata(aMRdata), .busy(aBusy)
`ifdef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
    , .misaligned(aMis)
`endif
  );

  mem_access_sequencer #(.XLEN(64), .ADDR_W(32), .MEM_LATENCY(LB)) uB (
    .clock(clock), .reset(reset), .req_valid(bValid), .req_ready(bReady), .req_store(bStore),
    .req_funct3(bF3), .req_addr(bAddr), .req_wdata(bWdata), .resp_valid(bRespV), .resp_rdata(bRdata),
    .mem_addr(bMAddr), .mem_re(bRe), .mem_we(bWe), .mem_wdata(bMWdata), .mem_rdata(bMRdata), .busy(bBusy)
`ifdef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
    , .misaligned(bMis)
`endif
  );

`ifndef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
  assign aMis = 1'b0;
  assign bMis = 1'b0;
`endif

  // Memory model for the 32-bit port: data appears LA cycles after the read strobe, then turns to junk
  always @(posedge clock) begin
    if (aWe) memA[32'(aMAddr >> 2)] = {32'h0, aMWdata};
    if (aRe) begin
      rdDataA = memA.exists(32'(aMAddr >> 2)) ? memA[32'(aMAddr >> 2)][31:0] : 32'h0;
      fork
        begin
          repeat (LA - 1) @(posedge clock);
          #1 aMRdata = rdDataA;
          @(posedge clock);
          #1 aMRdata = $urandom;
        end
      join_none
    end
  end

  // Memory model for the 64-bit port, same behaviour with latency LB
  always @(posedge clock) begin
    if (bWe) memB[32'(bMAddr >> 3)] = bMWdata;
    if (bRe) begin
      rdDataB = memB.exists(32'(bMAddr >> 3)) ? memB[32'(bMAddr >> 3)] : 64'h0;
      fork
        begin
          repeat (LB - 1) @(posedge clock);
          #1 bMRdata = rdDataB;
          @(posedge clock);
          #1 bMRdata = {$urandom, $urandom};
        end
      join_none
    end
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Matches one instance's strobes and responses against the scoreboard queues
  task automatic observe(input int sel, input logic re, input logic we, input logic rv, input logic mis,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata);
    ev_t e;
    if (re || we) checkOutput("strobeExcl", {63'h0, re && we}, 64'h0);
    if (re) begin
      if (reQ.size() == 0) checkOutput("unexpRe", 64'h1, 64'h0);
      else begin
        e = reQ.pop_front();
        checkOutput("reInst", 64'(sel), 64'(e.sel));
        checkOutput("reCycle", 64'(cyc), 64'(e.cyc));
        checkOutput("reAddr", addr, e.addr);
      end
    end
    if (we) begin
      if (weQ.size() == 0) checkOutput("unexpWe", 64'h1, 64'h0);
      else begin
        e = weQ.pop_front();
        checkOutput("weInst", 64'(sel), 64'(e.sel));
        checkOutput("weCycle", 64'(cyc), 64'(e.cyc));
        checkOutput("weAddr", addr, e.addr);
        checkOutput("weData", wdata, e.data);
      end
    end
    if (rv) begin
      if (rspQ.size() == 0) checkOutput("unexpResp", 64'h1, 64'h0);
      else begin
        e = rspQ.pop_front();
        checkOutput("respInst", 64'(sel), 64'(e.sel));
        checkOutput("respCycle", 64'(cyc), 64'(e.cyc));
        checkOutput("respData", rdata, e.data);
`ifdef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
        checkOutput("respMis", {63'h0, mis}, {63'h0, e.mis});
`endif
      end
    end
  endtask

  // Both monitors sample half a cycle away from the active edge, including during reset
  always @(negedge clock) begin
    observe(0, aRe, aWe, aRespV, aMis, {32'h0, aMAddr}, {32'h0, aMWdata}, {32'h0, aRdata});
    observe(1, bRe, bWe, bRespV, bMis, {32'h0, bMAddr}, bMWdata, bRdata);
  end

  // kind: 0 load, 1 full-width store, 2 sub-word store (preload), 3 misalignment trap
  task automatic applyStimulus(input int sel, input bit store, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wdata, input int kind, input logic [63:0] expData,
                               input bit holdBusy);
    int          t, lat;
    logic [63:0] al;
    @(negedge clock);
    t   = cyc;
    lat = (sel == 0) ? LA : LB;
    al  = addr & ~((sel == 0) ? 64'h3 : 64'h7);
    case (kind)
      0: begin
        reQ.push_back('{sel, t + 1, al, 64'h0, 1'b0});
        rspQ.push_back('{sel, t + lat + 2, al, expData, 1'b0});
      end
      1: begin
        weQ.push_back('{sel, t + 1, al, expData, 1'b0});
        rspQ.push_back('{sel, t + 2, al, 64'h0, 1'b0});
      end
      2: begin
        reQ.push_back('{sel, t + 1, al, 64'h0, 1'b0});
        weQ.push_back('{sel, t + lat + 2, al, expData, 1'b0});
        rspQ.push_back('{sel, t + lat + 3, al, 64'h0, 1'b0});
      end
      default: rspQ.push_back('{sel, t + 1, al, 64'h0, 1'b1});
    endcase
    if (sel == 0) begin
      aValid = 1; aStore = store; aF3 = f3; aAddr = addr[31:0]; aWdata = wdata[31:0];
    end else begin
      bValid = 1; bStore = store; bF3 = f3; bAddr = addr[31:0]; bWdata = wdata;
    end
    @(negedge clock);
    if (holdBusy) begin
      aAddr = 32'h0000_0204; bAddr = 32'h0000_0208;
      @(negedge clock);
    end
    aValid = 0; bValid = 0;
    for (int i = 0; i < 20 && rspQ.size() != 0; i++) @(negedge clock);
    if (rspQ.size() != 0) begin
      checkOutput("respTimeout", 64'(rspQ.size()), 64'h0);
      rspQ.delete();
    end
    @(negedge clock);
    checkOutput("reLeft", 64'(reQ.size()), 64'h0);
    checkOutput("weLeft", 64'(weQ.size()), 64'h0);
    reQ.delete();
    weQ.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] word;
    logic [7:0]  b;
    memA[32'h40] = 64'h0000_0000_80FF_7F01;
    memA[32'h80] = 64'h0000_0000_1122_3344;
    memB[32'h20] = 64'hF000_0000_1234_5678;
    memB[32'h40] = 64'h5566_7788_1122_3344;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rstReady", {63'h0, aReady}, 64'h1);
    checkOutput("rstBusy", {63'h0, aBusy}, 64'h0);
    checkOutput("rstResp", {63'h0, aRespV}, 64'h0);
    checkOutput("rstStrobes", {62'h0, aRe, aWe}, 64'h0);
    checkOutput("rstMemAddr", {32'h0, aMAddr}, 64'h0);
    checkOutput("rstMemWdata", {32'h0, aMWdata}, 64'h0);
    checkOutput("rstRdata", {32'h0, aRdata}, 64'h0);
    checkOutput("rstReadyB", {63'h0, bReady}, 64'h1);
    reset = 0;
    @(negedge clock);

    // 32-bit loads, latency 1
    applyStimulus(0, 0, 3'b000, 64'h102, 0, 0, 64'hFFFF_FFFF, 0);
    applyStimulus(0, 0, 3'b100, 64'h102, 0, 0, 64'h0000_00FF, 0);
    applyStimulus(0, 0, 3'b001, 64'h102, 0, 0, 64'hFFFF_80FF, 0);
    applyStimulus(0, 0, 3'b101, 64'h100, 0, 0, 64'h0000_7F01, 0);
    applyStimulus(0, 0, 3'b010, 64'h100, 0, 0, 64'h80FF_7F01, 0);
    applyStimulus(0, 0, 3'b111, 64'h100, 0, 0, 64'h80FF_7F01, 0);
    word = 32'h80FF_7F01;
    for (int i = 0; i < 4; i++) begin
      b = word[8*i +: 8];
      applyStimulus(0, 0, 3'b000, 64'(32'h100 + i), 0, 0, {32'h0, {24{b[7]}}, b}, 0);
    end
    applyStimulus(0, 0, 3'b101, 64'h102, 0, 0, 64'h0000_80FF, 1);

    // 32-bit stores
    applyStimulus(0, 1, 3'b010, 64'h200, 64'hDEAD_BEEF, 1, 64'hDEAD_BEEF, 0);
    applyStimulus(0, 1, 3'b000, 64'h201, 64'h0000_00AA, 2, 64'hDEAD_AAEF, 0);
    applyStimulus(0, 0, 3'b010, 64'h200, 0, 0, 64'hDEAD_AAEF, 0);

    // Misaligned word load
`ifdef MEM_ACCESS_SEQUENCER_MISALIGN_TRAP_EN
    applyStimulus(0, 0, 3'b010, 64'h103, 0, 3, 64'h0, 0);
`else
    applyStimulus(0, 0, 3'b010, 64'h103, 0, 0, 64'h80FF_7F01, 0);
`endif

    // Reset asserted while a halfword store waits on its preload
    @(negedge clock);
    reQ.push_back('{0, cyc + 1, 64'h200, 64'h0, 1'b0});
    aValid = 1; aStore = 1; aF3 = 3'b001; aAddr = 32'h202; aWdata = 32'h0000_1234;
    @(negedge clock);
    aValid = 0;
    @(negedge clock);
    reset = 1;
    #1;
    checkOutput("midRstBusy", {63'h0, aBusy}, 64'h0);
    checkOutput("midRstReady", {63'h0, aReady}, 64'h1);
    checkOutput("midRstStrobes", {62'h0, aRe, aWe}, 64'h0);
    checkOutput("midRstMemAddr", {32'h0, aMAddr}, 64'h0);
    checkOutput("midRstMemWdata", {32'h0, aMWdata}, 64'h0);
    checkOutput("midRstPreload", 64'(reQ.size()), 64'h0);
    repeat (3) @(negedge clock);
    reset = 0;
    applyStimulus(0, 0, 3'b010, 64'h200, 0, 0, 64'hDEAD_AAEF, 0);

    // 64-bit instance, latency 3
    applyStimulus(1, 0, 3'b110, 64'h104, 0, 0, 64'h0000_0000_F000_0000, 0);
    applyStimulus(1, 0, 3'b010, 64'h104, 0, 0, 64'hFFFF_FFFF_F000_0000, 0);
    applyStimulus(1, 0, 3'b011, 64'h100, 0, 0, 64'hF000_0000_1234_5678, 0);
    applyStimulus(1, 0, 3'b010, 64'h100, 0, 0, 64'h0000_0000_1234_5678, 1);
    applyStimulus(1, 1, 3'b000, 64'h201, 64'hAA, 2, 64'h5566_7788_1122_AA44, 0);
    applyStimulus(1, 1, 3'b001, 64'h206, 64'hBEEF, 2, 64'hBEEF_7788_1122_AA44, 0);
    applyStimulus(1, 0, 3'b011, 64'h200, 0, 0, 64'hBEEF_7788_1122_AA44, 0);
    applyStimulus(1, 1, 3'b011, 64'h208, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF, 0);
    applyStimulus(1, 0, 3'b001, 64'h20E, 0, 0, 64'h0000_0000_0000_0123, 0);
    applyStimulus(1, 0, 3'b000, 64'h20F, 0, 0, 64'h0000_0000_0000_0001, 0);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
